// File: rtl/alu_4bit.sv
// 4-bit MIPS-style ALU: AND/OR/ADD/SUB/SLT built from 1-bit cells plus a carry-lookahead unit.
// One clock of latency on every output except set, which is combinational so it can close the SLT loop.

module alu_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic binv_i,
  input  logic c_i,
  output logic g_o,
  output logic p_o,
  output logic sum_o
);
  logic bx;

  always_comb begin
    bx    = binv_i ? ~b_i : b_i;
    // g and p double as the AND and OR function results.
    g_o   = a_i & bx;
    p_o   = a_i | bx;
    sum_o = a_i ^ bx ^ c_i;
  end
endmodule

module cla4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c0_i,
  output logic [4:0] c_o,
  output logic       gg_o,
  output logic       pg_o
);
  always_comb begin
    gg_o   = g_i[3]
           | (p_i[3] & g_i[2])
           | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    pg_o   = &p_i;
    c_o[0] = c0_i;
    c_o[1] = g_i[0] | (p_i[0] & c0_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c0_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c0_i);
    c_o[4] = gg_o | (pg_o & c0_i);
  end
endmodule

module alu_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       cout,
  output logic       G,
  output logic       P,
  output logic       set,
  output logic       overflow,
  output logic       zero
);
  logic [3:0] g_w;
  logic [3:0] p_w;
  logic [3:0] sum_w;
  logic [4:0] c_w;
  logic       gg_w;
  logic       pg_w;
  logic       ovf_w;

  logic [3:0] result_d, result_q;
  logic       cout_q, g_q, p_q, ovf_q, zero_q;
  logic       zero_d;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    alu_cell u_cell (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .binv_i (op[2]),
      .c_i    (c_w[i]),
      .g_o    (g_w[i]),
      .p_o    (p_w[i]),
      .sum_o  (sum_w[i])
    );
  end

  cla4 u_cla (
    .g_i  (g_w),
    .p_i  (p_w),
    .c0_i (cin),
    .c_o  (c_w),
    .gg_o (gg_w),
    .pg_o (pg_w)
  );

  always_comb begin
    ovf_w = c_w[4] ^ c_w[3];
    // Correcting the sign bit with overflow keeps SLT right when a-b overflows.
    set   = sum_w[3] ^ ovf_w;
    result_d = 4'b0000;
    case (op[1:0])
      2'b00:   result_d = g_w;
      2'b01:   result_d = p_w;
      2'b10:   result_d = sum_w;
      default: result_d = {3'b000, less};
    endcase
    zero_d = ~|result_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 4'b0000;
      cout_q   <= 1'b0;
      g_q      <= 1'b0;
      p_q      <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= c_w[4];
      g_q      <= gg_w;
      p_q      <= pg_w;
      ovf_q    <= ovf_w;
      zero_q   <= zero_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign G        = g_q;
  assign P        = p_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: arithmetic reference model checked every cycle, plus pinned literal vectors.

module tb_alu_4bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin, less_drv, tie;
  logic [2:0] op;
  logic       less_w;
  logic [3:0] result;
  logic       cout, G, P, set, overflow, zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] res;
    logic       co, g, p, ovf, zero, set;
  } exp_t;

  exp_t exp_q = '0;

  assign less_w = tie ? set : less_drv;

  alu_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .less     (less_w),
    .op       (op),
    .result   (result),
    .cout     (cout),
    .G        (G),
    .P        (P),
    .set      (set),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic [2:0] mop,
                                 input logic mcin, input logic mtie, input logic mless);
    exp_t       r;
    logic [3:0] bx;
    logic [3:0] sum;
    int         u, s;
    logic       lv;
    r   = '0;
    bx  = mop[2] ? ~mb : mb;
    u   = int'(ma) + int'(bx) + int'(mcin);
    sum = u[3:0];
    s   = int'($signed(ma)) + int'($signed(bx)) + int'(mcin);
    r.co  = (u >= 16);
    r.ovf = (s > 7) || (s < -8);
    r.set = sum[3] ^ r.ovf;
    r.g   = (int'(ma) + int'(bx)) >= 16;
    r.p   = ((ma | bx) == 4'hF);
    lv    = mtie ? r.set : mless;
    case (mop[1:0])
      2'b00:   r.res = ma & bx;
      2'b01:   r.res = ma | bx;
      2'b10:   r.res = sum;
      default: r.res = {3'b000, lv};
    endcase
    r.zero = (r.res == 4'h0);
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
    end
  endtask

  // Reference state: loaded from the inputs at each rising edge, cleared asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = '0;
    else        exp_q = model(a, b, op, cin, tie, less_drv);
  end

  always @(negedge clk) begin
    exp_t cur;
    cur = model(a, b, op, cin, tie, less_drv);
    check("m_result",   {4'h0, result},   {4'h0, exp_q.res});
    check("m_cout",     {7'h0, cout},     {7'h0, exp_q.co});
    check("m_G",        {7'h0, G},        {7'h0, exp_q.g});
    check("m_P",        {7'h0, P},        {7'h0, exp_q.p});
    check("m_overflow", {7'h0, overflow}, {7'h0, exp_q.ovf});
    check("m_zero",     {7'h0, zero},     {7'h0, exp_q.zero});
    check("m_set",      {7'h0, set},      {7'h0, cur.set});
  end

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_v, input logic [2:0] to,
                       input logic tc, input logic tt, input logic tl);
    a = ta; b = tb_v; op = to; cin = tc; tie = tt; less_drv = tl;
  endtask

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb_v, input logic [2:0] to,
                       input logic tc, input logic tt, input logic tl);
    @(negedge clk);
    #1;
    drive(ta, tb_v, to, tc, tt, tl);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic [2:0] op;
    logic       cin;
    logic [3:0] res;
    logic       co, ovf, zero;
    string      nm;
  } vec_t;

  vec_t vecs[7];
  logic [3:0] slt_a[5];
  logic [3:0] slt_b[5];
  logic [3:0] slt_r[5];

  initial begin
    rst_n = 1'b0;
    drive(4'hF, 4'hF, 3'b010, 1'b1, 1'b0, 1'b1);

    // Registered outputs held at zero in reset regardless of inputs.
    @(negedge clk);
    @(negedge clk);
    check("rst_result",   {4'h0, result}, 8'h00);
    check("rst_cout",     {7'h0, cout},   8'h00);
    check("rst_zero",     {7'h0, zero},   8'h00);
    check("rst_overflow", {7'h0, overflow}, 8'h00);

    #1;
    rst_n = 1'b1;
    drive(4'h3, 4'h4, 3'b010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("first_add", {4'h0, result}, 8'h07);

    vecs[0] = '{4'hF, 4'h2, 3'b100, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0, "and_binv"};
    vecs[1] = '{4'h7, 4'h7, 3'b010, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, "add_7_7"};
    vecs[2] = '{4'h8, 4'h8, 3'b010, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, "add_8_8"};
    vecs[3] = '{4'h9, 4'h7, 3'b110, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, "sub_9_7"};
    vecs[4] = '{4'h9, 4'h9, 3'b110, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, "sub_9_9"};
    vecs[5] = '{4'h5, 4'hA, 3'b001, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, "or_5_a"};
    vecs[6] = '{4'h0, 4'hF, 3'b101, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, "or_binv"};
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, 1'b0, 1'b0);
      check({vecs[i].nm, "_result"}, {4'h0, result},   {4'h0, vecs[i].res});
      check({vecs[i].nm, "_zero"},   {7'h0, zero},     {7'h0, vecs[i].zero});
      if (vecs[i].op[1]) begin
        check({vecs[i].nm, "_cout"}, {7'h0, cout},     {7'h0, vecs[i].co});
        check({vecs[i].nm, "_ovf"},  {7'h0, overflow}, {7'h0, vecs[i].ovf});
      end
    end

    slt_a = '{4'h0, 4'h1, 4'h9, 4'hF, 4'hF};
    slt_b = '{4'h1, 4'h0, 4'hF, 4'h9, 4'h0};
    slt_r = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
    for (int i = 0; i < 5; i++) begin
      apply(slt_a[i], slt_b[i], 3'b111, 1'b1, 1'b1, 1'b0);
      check($sformatf("slt_%0d", i), {4'h0, result}, {4'h0, slt_r[i]});
    end

    // Asynchronous reset in the middle of traffic, then reload on the first edge after release.
    apply(4'h5, 4'hA, 3'b001, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result", {4'h0, result}, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_result", {4'h0, result}, 8'h0F);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        #1;
        drive(i[7:4], i[3:0], (s == 0) ? 3'b010 : 3'b110, s[0], 1'b0, 1'b0);
      end
    end

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      #1;
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
